rlwe_keygen_serial: RTL and testbench
=====================================

# rlwe_keygen_serial

Parametrised RLWE key generator computing b = a·s + e in Z_Q[x]/(x^N+1). It is the generalised successor of the fixed-size KeyGen. It takes coefficient streams from the TRNG (a) and the Gaussian sampler (s, then e), each with a request/ready handshake. It multiplies with a single-MAC negacyclic schoolbook engine and streams the key pair out under consumer backpressure.

## Interface
- Q, 17: modulus; requires 2^LOG_Q < 2·Q.
- LOG_Q, 5: coefficient width, equal to ceil(log2 Q).
- N, 8: ring degree, power of two.
- LOG_N, 3: log2 N.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- TRNG_req  out  1  high in LOAD_A.
- TRNG_ready  in  1  TRNG_in valid; a sample transfers when TRNG_req && TRNG_ready.
- TRNG_in  in  LOG_Q  uniform coefficient of a, index 0 first.
- Gaussian_req  out  1  high in LOAD_S and LOAD_E.
- Gaussian_ready  in  1  Gaussian_in valid; a sample transfers when Gaussian_req && Gaussian_ready.
- Gaussian_in  in  LOG_Q  coefficients of s[0..N-1], then e[0..N-1].
- key_ready  out  1  output coefficient valid.
- out_ack  in  1  consumer accepts the current coefficient when key_ready && out_ack.
- key_last  out  1  high with coefficient N-1.
- coeff_idx  out  LOG_N  index of the presented coefficient.
- pub_key_a, pub_key_b, sec_key_s  out  LOG_Q  coefficient coeff_idx of a, b and s.

## Operation
- States: IDLE → LOAD_A → LOAD_S → LOAD_E → MUL → OUT → IDLE.
- IDLE: start moves the block to LOAD_A and clears the counters. A start seen in any other state is ignored.
- LOAD_A, LOAD_S: each accepted sample is reduced, then written to mem_a or mem_s at the counter index. After the N-th transfer the block moves to the next state.
- Reduction: if the value is ≥ Q, subtract Q once.
- LOAD_E: e[k] is reduced and written to mem_b[k], which initialises the accumulator.
- MUL: nested counters i (outer) and j (inner), each running 0..N-1, one MAC per cycle.
  - k = (i+j) mod N.
  - If i+j < N: mem_b[k] ← (mem_b[k] + a[i]·s[j]) mod Q.
  - Otherwise: mem_b[k] ← (mem_b[k] − a[i]·s[j]) mod Q.
  - The product is 2·LOG_Q bits and is fully reduced mod Q in the same cycle. Results are always in [0,Q).
  - After i = j = N-1 the block moves to OUT.
- OUT: presents coefficient coeff_idx of a, b and s, starting at 0, with key_ready high.
  - The index advances on an ack.
  - The block returns to IDLE on the ack of index N-1.
- While key_ready is low, the data outputs, coeff_idx and key_last are 0.
- Mid-operation reset: the block is in IDLE on the next cycle with all outputs at reset values. Memory contents are not cleared and are don't-care.

## Timing
- Reset values: busy, TRNG_req, Gaussian_req, key_ready, key_last = 0; coeff_idx and all data outputs = 0.
- start at cycle t: LOAD_A begins at t+1.
- With the sources always ready, the cycle counts are:
  - LOAD_A: N cycles.
  - LOAD_S: N cycles.
  - LOAD_E: N cycles.
  - MUL: N² cycles.
  - First key_ready: t+1+3N+N². For N=8 this is t+89.
- Each stall cycle on an input handshake adds exactly one cycle and drops no sample.
- Backpressure: while out_ack is low, all outputs hold their values.
- The last ack is followed by IDLE on the next cycle, and busy falls then. start is accepted in that same cycle.

## Configuration
- KEYGEN_SIGNED_NOISE_EN defined:
  - Gaussian_in (s and e) is interpreted as signed two's complement.
  - Negative values map to value+Q.
  - Non-negative values use the normal reduction.
- KEYGEN_SIGNED_NOISE_EN undefined: Gaussian_in is unsigned and uses conditional-subtract reduction only.
- TRNG_in is unsigned in both builds.

## Structure
- Package rlwe_pkg holds:
  - the state enum typedef;
  - the conditional-subtract reduction function;
  - the signed-to-mod-Q mapping function.
- Sub-module mod_mac_q (Q, LOG_Q): combinational (acc ± x·y) mod Q, with a subtract select.
- The three coefficient memories are register arrays inside the top module.

## Test plan
- N=8, Q=17: a=1..8, s=(0,1,0,1,0,1,0,1), e=(1,1,0,1,1,0,0,0).
  - pub_key_b = 15,4,1,10,10,2,4,16.
  - pub_key_a = 1..8; sec_key_s echoes s.
  - key_last is high on index 7 only.
- Same vectors with TRNG_ready and Gaussian_ready low every other cycle: identical outputs; LOAD_A lasts 16 cycles.
- out_ack held low for 5 cycles at coeff_idx 3: pub_key_b stays 10; the sequence continues 10,2,4,16 with no skip or repeat.
- TRNG_in = 17..24 with s = 0 and e = 0: pub_key_a = 0..7 and pub_key_b all 0.
- Reset asserted mid-MUL: busy = 0 and key_ready = 0 on the next cycle; start pulses during the earlier run are ignored. A fresh run with the first vector gives the first-scenario result.
- s = 0, e = (31,1,0,0,0,0,0,0):
  - with KEYGEN_SIGNED_NOISE_EN, pub_key_b = 16,1,0,…;
  - without it, pub_key_b = 14,1,0,….

Source files
------------

// File: rtl/rlwe_pkg.sv
// Shared types and modular helpers for the RLWE key generator.
// Latency: combinational helpers only. Backpressure: not applicable.
// Reduction helpers assume inputs below 2^LOG_Q < 2*Q.
package rlwe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_S,
        ST_LOAD_E,
        ST_MUL,
        ST_OUT
    } state_t;

    // One conditional subtract is enough because inputs are below 2*q.
    function automatic logic [31:0] mod_csub(input logic [31:0] v, input logic [31:0] q);
        return (v >= q) ? (v - q) : v;
    endfunction

    // Two's-complement value of width w mapped into [0,q): negatives become v+q.
    function automatic logic [31:0] mod_signed(input logic [31:0] v, input logic [31:0] q,
                                               input int unsigned w);
        logic [31:0] half;
        logic [31:0] full;
        half = 32'd1 << (w - 1);
        full = 32'd1 << w;
        if (v >= half)
            return v + q - full;
        return mod_csub(v, q);
    endfunction

endpackage

// File: rtl/rlwe_keygen_serial_mac.sv
// Combinational modular MAC: res = (acc +/- x*y) mod Q, with acc in [0,Q).
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is written.
module mod_mac_q #(
    parameter int Q     = 17,
    parameter int LOG_Q = 5
) (
    input  logic [LOG_Q-1:0] acc,
    input  logic [LOG_Q-1:0] x,
    input  logic [LOG_Q-1:0] y,
    input  logic             sub,
    output logic [LOG_Q-1:0] res
);

    localparam logic [2*LOG_Q-1:0] Q_P = (2*LOG_Q)'(Q);
    localparam logic [LOG_Q:0]     Q_E = (LOG_Q+1)'(Q);

    logic [2*LOG_Q-1:0] prod;
    logic [LOG_Q-1:0]   prod_m;
    logic [LOG_Q:0]     sum;

    always_comb begin
        prod   = {{LOG_Q{1'b0}}, x} * {{LOG_Q{1'b0}}, y};
        prod_m = LOG_Q'(prod % Q_P);
        sum    = {1'b0, acc} + {1'b0, prod_m};
        res    = '0;
        if (sub) begin
            if (acc >= prod_m)
                res = acc - prod_m;
            else
                res = LOG_Q'({1'b0, acc} + Q_E - {1'b0, prod_m});
        end else begin
            if (sum >= Q_E)
                res = LOG_Q'(sum - Q_E);
            else
                res = sum[LOG_Q-1:0];
        end
    end

endmodule

// File: rtl/rlwe_keygen_serial.sv
// RLWE key generator b = a*s + e in Z_Q[x]/(x^N+1); KEYGEN_SIGNED_NOISE_EN selects signed noise.
// Latency: start to first key coefficient is 1+3N+N^2 cycles with sources always ready.
// Backpressure: input stalls extend the load phases; out_ack low freezes all outputs.
module rlwe_keygen_serial
    import rlwe_pkg::*;
#(
    parameter int Q     = 17,
    parameter int LOG_Q = 5,
    parameter int N     = 8,
    parameter int LOG_N = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             TRNG_req,
    input  logic             TRNG_ready,
    input  logic [LOG_Q-1:0] TRNG_in,
    output logic             Gaussian_req,
    input  logic             Gaussian_ready,
    input  logic [LOG_Q-1:0] Gaussian_in,
    output logic             key_ready,
    input  logic             out_ack,
    output logic             key_last,
    output logic [LOG_N-1:0] coeff_idx,
    output logic [LOG_Q-1:0] pub_key_a,
    output logic [LOG_Q-1:0] pub_key_b,
    output logic [LOG_Q-1:0] sec_key_s
);

    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

    state_t state_q, state_d;

    logic [LOG_N-1:0] cnt_q;
    logic [LOG_N-1:0] i_q;
    logic [LOG_N-1:0] j_q;

    logic [LOG_Q-1:0] mem_a [N];
    logic [LOG_Q-1:0] mem_s [N];
    logic [LOG_Q-1:0] mem_b [N];

    logic             trng_fire;
    logic             gauss_fire;
    logic [LOG_Q-1:0] a_red;
    logic [LOG_Q-1:0] g_red;
    logic [LOG_N:0]   ij_sum;
    logic [LOG_N-1:0] k_idx;
    logic [LOG_Q-1:0] mac_res;

    assign busy         = (state_q != ST_IDLE);
    assign TRNG_req     = (state_q == ST_LOAD_A);
    assign Gaussian_req = (state_q == ST_LOAD_S) || (state_q == ST_LOAD_E);
    assign key_ready    = (state_q == ST_OUT);
    assign trng_fire    = TRNG_req && TRNG_ready;
    assign gauss_fire   = Gaussian_req && Gaussian_ready;

    assign a_red = LOG_Q'(mod_csub(32'(TRNG_in), 32'(Q)));
`ifdef KEYGEN_SIGNED_NOISE_EN
    assign g_red = LOG_Q'(mod_signed(32'(Gaussian_in), 32'(Q), LOG_Q));
`else
    assign g_red = LOG_Q'(mod_csub(32'(Gaussian_in), 32'(Q)));
`endif

    // Carry out of i+j marks the wrap past x^N, where x^N = -1 flips the sign.
    assign ij_sum = {1'b0, i_q} + {1'b0, j_q};
    assign k_idx  = ij_sum[LOG_N-1:0];

    mod_mac_q #(
        .Q     (Q),
        .LOG_Q (LOG_Q)
    ) u_mac (
        .acc (mem_b[k_idx]),
        .x   (mem_a[i_q]),
        .y   (mem_s[j_q]),
        .sub (ij_sum[LOG_N]),
        .res (mac_res)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD_A;
            ST_LOAD_A: if (trng_fire && cnt_q == LAST) state_d = ST_LOAD_S;
            ST_LOAD_S: if (gauss_fire && cnt_q == LAST) state_d = ST_LOAD_E;
            ST_LOAD_E: if (gauss_fire && cnt_q == LAST) state_d = ST_MUL;
            ST_MUL:    if (i_q == LAST && j_q == LAST) state_d = ST_OUT;
            ST_OUT:    if (out_ack && cnt_q == LAST) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counters wrap to zero naturally because N is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                    end
                end
                ST_LOAD_A: if (trng_fire) cnt_q <= cnt_q + LOG_N'(1);
                ST_LOAD_S, ST_LOAD_E: if (gauss_fire) cnt_q <= cnt_q + LOG_N'(1);
                ST_MUL: begin
                    j_q <= j_q + LOG_N'(1);
                    if (j_q == LAST)
                        i_q <= i_q + LOG_N'(1);
                end
                ST_OUT: if (out_ack) cnt_q <= cnt_q + LOG_N'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (trng_fire)
            mem_a[cnt_q] <= a_red;
        if (gauss_fire && state_q == ST_LOAD_S)
            mem_s[cnt_q] <= g_red;
        if (gauss_fire && state_q == ST_LOAD_E)
            mem_b[cnt_q] <= g_red;
        else if (state_q == ST_MUL)
            mem_b[k_idx] <= mac_res;
    end

    assign coeff_idx = key_ready ? cnt_q : '0;
    assign key_last  = key_ready && (cnt_q == LAST);
    assign pub_key_a = key_ready ? mem_a[cnt_q] : '0;
    assign pub_key_b = key_ready ? mem_b[cnt_q] : '0;
    assign sec_key_s = key_ready ? mem_s[cnt_q] : '0;

endmodule

// File: tb/tb_rlwe_keygen_serial.sv
// Randomised and directed bench for rlwe_keygen_serial against a polynomial-level model.
module tb_rlwe_keygen_serial;

    localparam int Q     = 17;
    localparam int LOG_Q = 5;
    localparam int N     = 8;
    localparam int LOG_N = 3;
    localparam int BUDGET = 3000;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             busy;
    logic             TRNG_req;
    logic             TRNG_ready;
    logic [LOG_Q-1:0] TRNG_in;
    logic             Gaussian_req;
    logic             Gaussian_ready;
    logic [LOG_Q-1:0] Gaussian_in;
    logic             key_ready;
    logic             out_ack;
    logic             key_last;
    logic [LOG_N-1:0] coeff_idx;
    logic [LOG_Q-1:0] pub_key_a;
    logic [LOG_Q-1:0] pub_key_b;
    logic [LOG_Q-1:0] sec_key_s;

    always #5 clk = ~clk;

    rlwe_keygen_serial #(.Q(Q), .LOG_Q(LOG_Q), .N(N), .LOG_N(LOG_N)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .TRNG_req(TRNG_req), .TRNG_ready(TRNG_ready), .TRNG_in(TRNG_in),
        .Gaussian_req(Gaussian_req), .Gaussian_ready(Gaussian_ready), .Gaussian_in(Gaussian_in),
        .key_ready(key_ready), .out_ack(out_ack), .key_last(key_last), .coeff_idx(coeff_idx),
        .pub_key_a(pub_key_a), .pub_key_b(pub_key_b), .sec_key_s(sec_key_s)
    );

    int n_vec = 0;
    int n_err = 0;

    int va [N];
    int vs [N];
    int ve [N];
    int ma [N];
    int ms [N];
    int mb [N];
    int ob [N];
    int oa [N];
    int first_kr;
    int loada_cyc;

    int spec_b [N] = '{15, 4, 1, 10, 10, 2, 4, 16};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int red(input int v);
        return (v >= Q) ? v - Q : v;
    endfunction

    function automatic int gmap(input int v);
`ifdef KEYGEN_SIGNED_NOISE_EN
        if (v >= (1 << (LOG_Q - 1)))
            return v - (1 << LOG_Q) + Q;
`endif
        return red(v);
    endfunction

    // Schoolbook negacyclic product on integers, reduced only at the end.
    task automatic model();
        int acc [N];
        for (int k = 0; k < N; k++) begin
            ma[k]  = red(va[k]);
            ms[k]  = gmap(vs[k]);
            acc[k] = gmap(ve[k]);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i + j < N) acc[i + j] += ma[i] * ms[j];
                else           acc[i + j - N] -= ma[i] * ms[j];
        for (int k = 0; k < N; k++)
            mb[k] = ((acc[k] % Q) + Q) % Q;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LOG_Q-1:0] gauss_word(input int pg);
        if (pg < N)     return LOG_Q'(vs[pg]);
        if (pg < 2 * N) return LOG_Q'(ve[pg - N]);
        return '0;
    endfunction

    // stall: 0 always ready, 1 ready on every second request cycle, 2 random.
    // ackm: 0 always ack, 1 hold five cycles at index 3, 2 random.
    task automatic run(input int stall, input int ackm);
        int  pa, pg, oi, cyc, hold, tph, gph;
        bit  done;
        model();
        pa = 0; pg = 0; oi = 0; hold = 0; tph = 0; gph = 0; done = 0;
        first_kr = -1; loada_cyc = 0;
        start = 1'b1;
        TRNG_ready = 1'b0; Gaussian_ready = 1'b0; out_ack = 1'b0;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < BUDGET) begin
            case (stall)
                0:       begin TRNG_ready = 1'b1; Gaussian_ready = 1'b1; end
                1:       begin TRNG_ready = tph[0]; Gaussian_ready = gph[0]; end
                default: begin TRNG_ready = 1'($urandom_range(0, 1)); Gaussian_ready = 1'($urandom_range(0, 1)); end
            endcase
            TRNG_in     = (pa < N) ? LOG_Q'(va[pa]) : '0;
            Gaussian_in = gauss_word(pg);
            case (ackm)
                0: out_ack = 1'b1;
                1: begin
                    if (key_ready && oi == 3 && hold < 5) begin
                        out_ack = 1'b0;
                        hold++;
                    end else begin
                        out_ack = 1'b1;
                    end
                end
                default: out_ack = 1'($urandom_range(0, 1));
            endcase
            if (TRNG_req) begin
                loada_cyc++;
                tph ^= 1;
                if (TRNG_ready) pa++;
            end
            if (Gaussian_req) begin
                gph ^= 1;
                if (Gaussian_ready) pg++;
            end
            if (key_ready) begin
                if (first_kr < 0) first_kr = cyc;
                check("coeff_idx", 32'(coeff_idx), 32'(oi));
                check("pub_key_a", 32'(pub_key_a), 32'(ma[oi]));
                check("pub_key_b", 32'(pub_key_b), 32'(mb[oi]));
                check("sec_key_s", 32'(sec_key_s), 32'(ms[oi]));
                check("key_last", 32'(key_last), 32'(oi == N - 1));
                if (out_ack) begin
                    ob[oi] = int'(pub_key_b);
                    oa[oi] = int'(pub_key_a);
                    if (oi == N - 1) done = 1;
                    oi++;
                end
            end else if (cyc % 16 == 3) begin
                check("idle_outputs_zero",
                      32'({coeff_idx, key_last, pub_key_a, pub_key_b, sec_key_s}), 32'd0);
            end
            tick();
            cyc++;
        end
        out_ack = 1'b0;
        check("run_completed", 32'(done), 32'd1);
        check("busy_after_last_ack", 32'(busy), 32'd0);
        check("key_ready_after_last_ack", 32'(key_ready), 32'd0);
        check("samples_a", 32'(pa), 32'(N));
        check("samples_se", 32'(pg), 32'(2 * N));
    endtask

    task automatic load_first_vector();
        for (int k = 0; k < N; k++) begin
            va[k] = k + 1;
            vs[k] = k % 2;
        end
        ve = '{1, 1, 0, 1, 1, 0, 0, 0};
    endtask

    initial begin
        int late_req, pa, pg;
        reset = 1'b1; start = 1'b0; out_ack = 1'b0;
        TRNG_ready = 1'b0; TRNG_in = '0; Gaussian_ready = 1'b0; Gaussian_in = '0;
        tick(); tick(); tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_reqs", 32'({TRNG_req, Gaussian_req}), 32'd0);
        check("reset_key_ready", 32'(key_ready), 32'd0);
        check("reset_outputs",
              32'({key_last, coeff_idx, pub_key_a, pub_key_b, sec_key_s}), 32'd0);
        reset = 1'b0;
        tick();

        load_first_vector();
        run(0, 0);
        check("first_key_ready_latency", 32'(first_kr), 32'(1 + 3 * N + N * N));
        check("load_a_cycles", 32'(loada_cyc), 32'(N));
        for (int k = 0; k < N; k++) begin
            check("vec1_b", 32'(ob[k]), 32'(spec_b[k]));
            check("vec1_a", 32'(oa[k]), 32'(k + 1));
        end

        run(1, 0);
        check("stalled_load_a_cycles", 32'(loada_cyc), 32'(2 * N));
        for (int k = 0; k < N; k++)
            check("stalled_b", 32'(ob[k]), 32'(spec_b[k]));

        run(0, 1);
        for (int k = 0; k < N; k++)
            check("held_b", 32'(ob[k]), 32'(spec_b[k]));

        for (int k = 0; k < N; k++) begin
            va[k] = 17 + k; vs[k] = 0; ve[k] = 0;
        end
        run(0, 0);
        for (int k = 0; k < N; k++) begin
            check("reduced_a", 32'(oa[k]), 32'(k));
            check("zero_b", 32'(ob[k]), 32'd0);
        end

        load_first_vector();
        late_req = 0; pa = 0; pg = 0;
        start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 50; cyc++) begin
            TRNG_ready = 1'b1; Gaussian_ready = 1'b1;
            TRNG_in = (pa < N) ? LOG_Q'(va[pa]) : '0;
            Gaussian_in = gauss_word(pg);
            start = (cyc == 12 || cyc == 40);
            if (TRNG_req) begin
                pa++;
                if (cyc > N) late_req++;
            end
            if (Gaussian_req) pg++;
            tick();
        end
        start = 1'b0;
        check("start_ignored_no_reload", 32'(late_req), 32'd0);
        check("mid_mul_busy", 32'(busy), 32'd1);
        check("mid_mul_no_key", 32'(key_ready), 32'd0);
        reset = 1'b1;
        tick();
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_key_ready", 32'(key_ready), 32'd0);
        check("mid_reset_outputs",
              32'({TRNG_req, Gaussian_req, key_last, coeff_idx, pub_key_a, pub_key_b, sec_key_s}), 32'd0);
        reset = 1'b0;
        tick();
        run(0, 0);
        for (int k = 0; k < N; k++)
            check("after_reset_b", 32'(ob[k]), 32'(spec_b[k]));

        for (int k = 0; k < N; k++) begin
            va[k] = $urandom_range(0, (1 << LOG_Q) - 1);
            vs[k] = 0; ve[k] = 0;
        end
        ve[0] = 31; ve[1] = 1;
        run(0, 0);
`ifdef KEYGEN_SIGNED_NOISE_EN
        check("noise_b0", 32'(ob[0]), 32'd16);
`else
        check("noise_b0", 32'(ob[0]), 32'd14);
`endif
        check("noise_b1", 32'(ob[1]), 32'd1);
        check("noise_b2", 32'(ob[2]), 32'd0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) begin
                va[k] = $urandom_range(0, (1 << LOG_Q) - 1);
                vs[k] = $urandom_range(0, (1 << LOG_Q) - 1);
                ve[k] = $urandom_range(0, (1 << LOG_Q) - 1);
            end
            run(2, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
